// File: rtl/ninjakun_palette_pkg.sv
// +----------------------------------------------------------------------+
// | ninjakun_palette_pkg : palette entry layout, FSM encoding, expansion |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ninjakun_palette_pkg;

    localparam int PAL_AW = 9;
    localparam int PAL_DW = 8;

    // Entry layout {R[2:0],G[2:0],B[1:0]}
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef struct packed {
        logic [PAL_AW-1:0] ad;
        logic              blank;
    } pix_req_t;

    // Replicate the channel MSBs so full-scale entries reach 4'hF
    function automatic logic [11:0] pal_expand(input logic [PAL_DW-1:0] e);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = e[R_MSB:R_LSB];
        g = e[G_MSB:G_LSB];
        b = e[B_MSB:B_LSB];
        return {r, r[2], g, g[2], b, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ninjakun_palram.sv
// +----------------------------------------------------------------------+
// | ninjakun_palram : 512x8 palette RAM, pixel read port + CPU R/W port  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ninjakun_palram
    import ninjakun_palette_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_re,
    input  logic [PAL_AW-1:0] pix_ad,
    output logic [PAL_DW-1:0] pix_q,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [PAL_AW-1:0] cpu_ad,
    input  logic [PAL_DW-1:0] cpu_di,
    output logic [PAL_DW-1:0] cpu_q
);

    logic [PAL_DW-1:0] r_mem [0:(1<<PAL_AW)-1];
    logic [PAL_DW-1:0] r_pix_q;
    logic [PAL_DW-1:0] r_cpu_q;

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            r_mem[cpu_ad] <= cpu_di;
        end
    end

    // Read-before-write: a same-cycle write is not seen by either read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_q <= '0;
            r_cpu_q <= '0;
        end else begin
            if (pix_re) begin
                r_pix_q <= r_mem[pix_ad];
            end
            if (cpu_re) begin
                r_cpu_q <= r_mem[cpu_ad];
            end
        end
    end

    assign pix_q = r_pix_q;
    assign cpu_q = r_cpu_q;

endmodule

`default_nettype wire

// File: rtl/ninjakun_palette.sv
// +----------------------------------------------------------------------+
// | ninjakun_palette : palette index -> RGB444, CPU access, power-on clear|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ninjakun_palette
    import ninjakun_palette_pkg::*;
#(
    parameter logic [7:0] CLRVAL = 8'h00
) (
    input  logic        VCLKx4,
    input  logic        RESET,
    input  logic        PCE,
    input  logic [8:0]  PALAD,
    input  logic        HBLK,
    input  logic        VBLK,
    input  logic [8:0]  CPUAD,
    input  logic [7:0]  CPUDI,
    input  logic        CPUWR,
    input  logic        CPURD,
    output logic [7:0]  CPUDO,
    output logic        CPURDY,
    output logic [11:0] POUT,
    output logic        BUSY
);

    logic              r_pce_d;
    pix_req_t          r_pix;
    logic [11:0]       r_pout;
    logic [1:0]        r_state;
    logic [9:0]        r_clr_cnt;
    logic [PAL_AW-1:0] r_cpu_ad;
    logic [PAL_DW-1:0] r_cpu_di;
    logic              r_cpu_wr;
    logic              r_rdy;

    logic [9:0]        w_clr_next;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [PAL_AW-1:0] w_ram_ad;
    logic [PAL_DW-1:0] w_ram_di;
    logic [PAL_DW-1:0] w_pix_q;
    logic [PAL_DW-1:0] w_cpu_q;

    // The cycle after PCE is reserved for the pixel read
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            r_pce_d <= 1'b0;
        end else begin
            r_pce_d <= PCE;
        end
    end

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            r_pix  <= '0;
            r_pout <= 12'h000;
        end else if (PCE) begin
            r_pix.ad    <= PALAD;
            r_pix.blank <= HBLK | VBLK;
            r_pout      <= r_pix.blank ? 12'h000 : pal_expand(w_pix_q);
        end
    end

    assign w_clr_next = r_clr_cnt + 10'd1;

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_cpu_ad  <= '0;
            r_cpu_di  <= '0;
            r_cpu_wr  <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_rdy <= (r_state == ST_ACCESS);
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= w_clr_next;
                    if (w_clr_next[9]) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if ((CPUWR | CPURD) && !r_pce_d) begin
                        r_cpu_ad <= CPUAD;
                        r_cpu_di <= CPUDI;
                        r_cpu_wr <= CPUWR;
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // RESET gates the port so an access in flight never lands
    always_comb begin
        w_ram_we = 1'b0;
        w_ram_re = 1'b0;
        w_ram_ad = r_cpu_ad;
        w_ram_di = r_cpu_di;
        if (!RESET) begin
            case (r_state)
                ST_CLEAR: begin
                    w_ram_we = 1'b1;
                    w_ram_ad = r_clr_cnt[8:0];
                    w_ram_di = CLRVAL;
                end
                ST_ACCESS: begin
                    w_ram_we = r_cpu_wr;
                    w_ram_re = !r_cpu_wr;
                end
                default: begin
                end
            endcase
        end
    end

    ninjakun_palram u_palram (
        .clk    (VCLKx4),
        .rst    (RESET),
        .pix_re (r_pce_d),
        .pix_ad (r_pix.ad),
        .pix_q  (w_pix_q),
        .cpu_we (w_ram_we),
        .cpu_re (w_ram_re),
        .cpu_ad (w_ram_ad),
        .cpu_di (w_ram_di),
        .cpu_q  (w_cpu_q)
    );

    assign CPUDO  = w_cpu_q;
    assign CPURDY = r_rdy;
    assign POUT   = r_pout;
    assign BUSY   = (r_state == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_ninjakun_palette.sv
// +----------------------------------------------------------------------+
// | tb_ninjakun_palette : vector table + scoreboard bench for the palette|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ninjakun_palette;

    localparam logic [7:0] CLRVAL = 8'h00;

    logic        VCLKx4;
    logic        RESET;
    logic        PCE;
    logic [8:0]  PALAD;
    logic        HBLK;
    logic        VBLK;
    logic [8:0]  CPUAD;
    logic [7:0]  CPUDI;
    logic        CPUWR;
    logic        CPURD;
    logic [7:0]  CPUDO;
    logic        CPURDY;
    logic [11:0] POUT;
    logic        BUSY;

    ninjakun_palette #(.CLRVAL(CLRVAL)) dut (
        .VCLKx4 (VCLKx4),
        .RESET  (RESET),
        .PCE    (PCE),
        .PALAD  (PALAD),
        .HBLK   (HBLK),
        .VBLK   (VBLK),
        .CPUAD  (CPUAD),
        .CPUDI  (CPUDI),
        .CPUWR  (CPUWR),
        .CPURD  (CPURD),
        .CPUDO  (CPUDO),
        .CPURDY (CPURDY),
        .POUT   (POUT),
        .BUSY   (BUSY)
    );

    initial VCLKx4 = 1'b0;
    always #5 VCLKx4 = ~VCLKx4;

    typedef struct {
        logic [8:0]  ad;
        logic [7:0]  d;
        logic        hb;
        logic        vb;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [8:0] ad;
        logic [7:0] d;
    } cpu_txn_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        pce_edge = 1'b0;
    logic        pix_en = 1'b0;
    logic [7:0]  model [512];
    logic [11:0] pix_q [$];
    cpu_txn_t    cpu_q [$];
    vec_t        vecs [8];

    function automatic logic [11:0] color(input logic [7:0] e);
        return {e[7:5], e[7], e[4:2], e[4], e[1:0], e[1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge VCLKx4);
        pce_edge = PCE;
        #1;
        cyc++;
        PCE = (cyc % 4 == 0);
    endtask

    task automatic wait_pce_cycle();
        while (PCE !== 1'b1) step();
    endtask

    task automatic next_pce_edge();
        do step(); while (pce_edge !== 1'b1);
    endtask

    task automatic cpu_access(input logic wr, input logic [8:0] a, input logic [7:0] d,
                              input int lo, input int hi, input int bound);
        int lat;
        cpu_txn_t t;
        t.wr = wr;
        t.ad = a;
        t.d  = d;
        cpu_q.push_back(t);
        CPUAD = a;
        CPUDI = d;
        CPUWR = wr;
        CPURD = !wr;
        lat = 0;
        do begin
            step();
            lat++;
        end while (CPURDY !== 1'b1 && lat < bound);
        CPUWR = 1'b0;
        CPURD = 1'b0;
        n_checks++;
        if (CPURDY !== 1'b1) begin
            n_errors++;
            $display("FAIL cpu_timeout: no CPURDY after %0d cycles", lat);
        end else if (lat < lo || lat > hi) begin
            n_errors++;
            $display("FAIL cpu_lat: got %0d cycles expected %0d..%0d", lat, lo, hi);
        end
    endtask

    // Reference model: pixel colour is taken from memory as it stands at the
    // read edge (before a write committed on that same edge).
    task automatic monitor();
        logic       pce_s, rst_s, blk_s, en_s;
        logic [8:0] ad_s;
        logic       rd_pend, lat_blk, lat_en;
        logic [8:0] lat_ad;
        logic [11:0] e;
        cpu_txn_t   t;
        rd_pend = 1'b0;
        lat_blk = 1'b0;
        lat_en  = 1'b0;
        lat_ad  = '0;
        forever begin
            @(posedge VCLKx4);
            pce_s = PCE;
            rst_s = RESET;
            ad_s  = PALAD;
            blk_s = HBLK | VBLK;
            en_s  = pix_en;
            if (rst_s) begin
                pix_q.delete();
                cpu_q.delete();
                for (int i = 0; i < 512; i++) model[i] = CLRVAL;
            end
            #1;
            if (!rst_s) begin
                if (rd_pend && lat_en)
                    pix_q.push_back(lat_blk ? 12'h000 : color(model[lat_ad]));
                if (CPURDY === 1'b1) begin
                    if (cpu_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL cpu_rdy_unexpected: CPURDY=1 with no access pending (cycle %0d)", cyc);
                    end else begin
                        t = cpu_q.pop_front();
                        if (t.wr) model[t.ad] = t.d;
                        else check("cpu_rd_data", {24'd0, CPUDO}, {24'd0, model[t.ad]});
                    end
                end
                if (pce_s && pix_q.size() > 0) begin
                    e = pix_q.pop_front();
                    check("pix_sb", {20'd0, POUT}, {20'd0, e});
                end
            end
            rd_pend = pce_s && !rst_s;
            if (pce_s) begin
                lat_ad  = ad_s;
                lat_blk = blk_s;
                lat_en  = en_s;
            end
        end
    endtask

    initial begin
        int n;
        RESET = 1'b1;
        PCE   = 1'b0;
        PALAD = '0;
        HBLK  = 1'b0;
        VBLK  = 1'b0;
        CPUAD = '0;
        CPUDI = '0;
        CPUWR = 1'b0;
        CPURD = 1'b0;

        vecs[0] = '{ad: 9'h055, d: 8'hE7, hb: 1'b0, vb: 1'b0, exp: 12'hF2F};
        vecs[1] = '{ad: 9'h0AA, d: 8'hFF, hb: 1'b0, vb: 1'b0, exp: 12'hFFF};
        vecs[2] = '{ad: 9'h1FF, d: 8'h92, hb: 1'b0, vb: 1'b0, exp: 12'h99A};
        vecs[3] = '{ad: 9'h100, d: 8'h6D, hb: 1'b0, vb: 1'b0, exp: 12'h665};
        vecs[4] = '{ad: 9'h000, d: 8'h1C, hb: 1'b0, vb: 1'b0, exp: 12'h0F0};
        vecs[5] = '{ad: 9'h123, d: 8'hE3, hb: 1'b1, vb: 1'b0, exp: 12'h000};
        vecs[6] = '{ad: 9'h123, d: 8'hE3, hb: 1'b0, vb: 1'b0, exp: 12'hF0F};
        vecs[7] = '{ad: 9'h124, d: 8'h03, hb: 1'b0, vb: 1'b1, exp: 12'h000};

        fork
            monitor();
        join_none

        // Reset values and clear length
        step();
        step();
        check("rst_pout", {20'd0, POUT}, 32'h000);
        check("rst_cpurdy", {31'd0, CPURDY}, 32'd0);
        check("rst_cpudo", {24'd0, CPUDO}, 32'h00);
        check("rst_busy", {31'd0, BUSY}, 32'd1);
        RESET = 1'b0;
        n = 0;
        while (BUSY === 1'b1 && n < 600) begin
            n++;
            step();
        end
        check("busy_len", n, 512);
        check("busy_low", {31'd0, BUSY}, 32'd0);

        // Every entry reads back as the clear value
        pix_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            PALAD = 9'(511 - i);
            cpu_access(1'b0, 9'(i), 8'h00, 2, 3, 10);
        end
        check("clr_pout", {20'd0, POUT}, 32'h000);

        // Colour table through the pixel path
        for (int i = 0; i < 8; i++) begin
            cpu_access(1'b1, vecs[i].ad, vecs[i].d, 2, 3, 10);
            PALAD = vecs[i].ad;
            HBLK  = vecs[i].hb;
            VBLK  = vecs[i].vb;
            repeat (10) step();
            check("vec_pout", {20'd0, POUT}, {20'd0, vecs[i].exp});
        end
        HBLK = 1'b0;
        VBLK = 1'b0;

        // Request arriving in the pixel-read slot waits one extra cycle
        PALAD = 9'h055;
        wait_pce_cycle();
        step();
        cpu_access(1'b0, 9'h055, 8'h00, 3, 3, 10);
        check("slot_cpudo", {24'd0, CPUDO}, 32'hE7);
        repeat (9) step();
        check("slot_pout", {20'd0, POUT}, 32'hF2F);

        // Request in a PCE cycle is serviced with minimum latency
        wait_pce_cycle();
        cpu_access(1'b0, 9'h0AA, 8'h00, 2, 2, 10);
        check("fast_cpudo", {24'd0, CPUDO}, 32'hFF);
        repeat (3) step();
        check("cpudo_hold", {24'd0, CPUDO}, 32'hFF);

        // Write and pixel read of the same address in the same cycle
        PALAD = 9'h1FF;
        repeat (8) step();
        wait_pce_cycle();
        cpu_access(1'b1, 9'h1FF, 8'hFF, 2, 2, 10);
        next_pce_edge();
        check("coll_old", {20'd0, POUT}, 32'h99A);
        next_pce_edge();
        check("coll_new", {20'd0, POUT}, 32'hFFF);

        // Reset while an access is in flight
        wait_pce_cycle();
        CPUAD = 9'h0AA;
        CPUDI = 8'h5A;
        CPUWR = 1'b1;
        step();
        RESET  = 1'b1;
        CPUWR  = 1'b0;
        pix_en = 1'b0;
        step();
        check("rst2_cpurdy", {31'd0, CPURDY}, 32'd0);
        check("rst2_busy", {31'd0, BUSY}, 32'd1);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst2_norody", {31'd0, CPURDY}, 32'd0);
            check("rst2_busy_hold", {31'd0, BUSY}, 32'd1);
        end
        cpu_access(1'b0, 9'h0AA, 8'h00, 511, 512, 600);
        check("rst2_cpudo", {24'd0, CPUDO}, 32'h00);
        check("rst2_busy_low", {31'd0, BUSY}, 32'd0);
        pix_en = 1'b1;
        repeat (10) step();
        check("rst2_pout", {20'd0, POUT}, 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
